// File: rtl/wb_arbiter.sv
// Two-requester write-back arbiter (ALU vs load unit) with round-robin priority,
// registered register-file write port and a saturating contention counter.
module wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wb_en,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    output logic              regWrite,
    output logic [ADDR_W-1:0] writeReg,
    output logic [DATA_W-1:0] writeData,
    output logic [15:0]       conflict_cnt
);

    logic              prio_q, prio_d;
    logic              reg_write_q, reg_write_d;
    logic [ADDR_W-1:0] write_reg_q, write_reg_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic [15:0]       conflict_cnt_q, conflict_cnt_d;
    logic [ADDR_W-1:0] grant_rd;
    logic [DATA_W-1:0] grant_data;
    logic              grant_any;

    always_comb begin
        // reset_n gates the grants so nothing is acknowledged while held in reset
        alu_ready  = reset_n & wb_en & alu_valid & (~mem_valid | ~prio_q);
        mem_ready  = reset_n & wb_en & mem_valid & (~alu_valid | prio_q);
        grant_any  = alu_ready | mem_ready;
        grant_rd   = mem_ready ? mem_rd : alu_rd;
        grant_data = mem_ready ? mem_data : alu_data;

        prio_d = prio_q;
        if (alu_ready) begin
            prio_d = 1'b1;
        end else if (mem_ready) begin
            prio_d = 1'b0;
        end

        // writes to r0 are consumed but never reach the register file
        reg_write_d  = grant_any && (grant_rd != '0);
        write_reg_d  = reg_write_d ? grant_rd : write_reg_q;
        write_data_d = reg_write_d ? grant_data : write_data_q;

        conflict_cnt_d = conflict_cnt_q;
        if (wb_en && alu_valid && mem_valid && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio_q         <= 1'b0;
            reg_write_q    <= 1'b0;
            write_reg_q    <= '0;
            write_data_q   <= '0;
            conflict_cnt_q <= '0;
        end else begin
            prio_q         <= prio_d;
            reg_write_q    <= reg_write_d;
            write_reg_q    <= write_reg_d;
            write_data_q   <= write_data_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign regWrite     = reg_write_q;
    assign writeReg     = write_reg_q;
    assign writeData    = write_data_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, random traffic against a
// round-robin reference model, counter saturation and mid-cycle reset.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wb_en;
    logic        alu_valid, mem_valid;
    logic [4:0]  alu_rd, mem_rd;
    logic [31:0] alu_data, mem_data;
    logic        alu_ready, mem_ready;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic [15:0] conflict_cnt;

    wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .reset_n(reset_n), .wb_en(wb_en),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    int          m_turn;      // who wins the next tie: 0 ALU, 1 MEM
    int          m_grant;     // -1 none, 0 ALU, 1 MEM (this cycle)
    logic        m_rw;
    logic [4:0]  m_wr;
    logic [31:0] m_wd;
    int          m_cnt;

    // sampled DUT values
    logic        act_ar, act_mr, act_rw;
    logic [4:0]  act_wr;
    logic [31:0] act_wd;
    logic [15:0] act_cnt;

    typedef struct {
        logic        en;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic        e_ar;
        logic        e_mr;
        logic        e_rw;
        logic [4:0]  e_wr;
        logic [31:0] e_wd;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_turn = 0; m_rw = 1'b0; m_wr = '0; m_wd = '0; m_cnt = 0; m_grant = -1;
    endtask

    // One clock cycle: apply inputs, sample readys, clock, update model, sample outputs.
    task automatic step(input logic en, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        int   rd;
        wb_en = en; alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        #1;
        act_ar = alu_ready; act_mr = mem_ready;
        if (!en)            m_grant = -1;
        else if (av && mv)  m_grant = m_turn;
        else if (av)        m_grant = 0;
        else if (mv)        m_grant = 1;
        else                m_grant = -1;
        @(posedge clk);
        if (en && av && mv) m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        if (m_grant >= 0) begin
            m_turn = 1 - m_grant;
            rd = (m_grant == 1) ? int'(mrd) : int'(ard);
            m_rw = (rd != 0);
            if (rd != 0) begin
                m_wr = 5'(rd);
                m_wd = (m_grant == 1) ? md : ad;
            end
        end else begin
            m_rw = 1'b0;
        end
        #1;
        act_rw = regWrite; act_wr = writeReg; act_wd = writeData; act_cnt = conflict_cnt;
        @(negedge clk);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".alu_ready"}, 32'(act_ar), 32'(m_grant == 0));
        chk({tag, ".mem_ready"}, 32'(act_mr), 32'(m_grant == 1));
        chk({tag, ".regWrite"},  32'(act_rw), 32'(m_rw));
        chk({tag, ".writeReg"},  32'(act_wr), 32'(m_wr));
        chk({tag, ".writeData"}, act_wd, m_wd);
        chk({tag, ".conflict"},  32'(act_cnt), 32'(m_cnt));
    endtask

    initial begin
        int alu_wait;
        int mem_wait;
        logic en, av, mv;

        tbl[0] = '{1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,
                   1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 16'd0};
        tbl[1] = '{1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h12345678,
                   1'b0, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 16'd0};
        tbl[2] = '{1'b1, 1'b1, 5'd1, 32'h11111111, 1'b1, 5'd2, 32'h22222222,
                   1'b1, 1'b0, 1'b1, 5'd1, 32'h11111111, 16'd1};
        tbl[3] = '{1'b1, 1'b1, 5'd1, 32'h11111111, 1'b1, 5'd2, 32'h22222222,
                   1'b0, 1'b1, 1'b1, 5'd2, 32'h22222222, 16'd2};
        tbl[4] = '{1'b1, 1'b1, 5'd1, 32'h11111111, 1'b1, 5'd2, 32'h22222222,
                   1'b1, 1'b0, 1'b1, 5'd1, 32'h11111111, 16'd3};
        tbl[5] = '{1'b1, 1'b1, 5'd1, 32'h11111111, 1'b1, 5'd2, 32'h22222222,
                   1'b0, 1'b1, 1'b1, 5'd2, 32'h22222222, 16'd4};
        tbl[6] = '{1'b0, 1'b1, 5'd3, 32'h33333333, 1'b1, 5'd4, 32'h44444444,
                   1'b0, 1'b0, 1'b0, 5'd2, 32'h22222222, 16'd4};
        tbl[7] = tbl[6];
        tbl[8] = tbl[6];
        tbl[9] = '{1'b1, 1'b0, 5'd7, 32'h77777777, 1'b0, 5'd8, 32'h88888888,
                   1'b0, 1'b0, 1'b0, 5'd2, 32'h22222222, 16'd4};

        // reset held: outputs cleared even with requests pending
        reset_n = 1'b0; wb_en = 1'b1; alu_valid = 1'b1; mem_valid = 1'b1;
        alu_rd = 5'd1; alu_data = 32'hAAAA5555; mem_rd = 5'd2; mem_data = 32'h5555AAAA;
        #2;
        chk("rst.alu_ready", 32'(alu_ready), 32'd0);
        chk("rst.mem_ready", 32'(mem_ready), 32'd0);
        chk("rst.regWrite",  32'(regWrite), 32'd0);
        chk("rst.writeReg",  32'(writeReg), 32'd0);
        chk("rst.writeData", writeData, 32'd0);
        chk("rst.conflict",  32'(conflict_cnt), 32'd0);
        #5;
        wb_en = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
        reset_n = 1'b1;
        model_reset();
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].en, tbl[i].av, tbl[i].ard, tbl[i].ad, tbl[i].mv, tbl[i].mrd, tbl[i].md);
            chk($sformatf("vec%0d.alu_ready", i), 32'(act_ar), 32'(tbl[i].e_ar));
            chk($sformatf("vec%0d.mem_ready", i), 32'(act_mr), 32'(tbl[i].e_mr));
            chk($sformatf("vec%0d.regWrite", i),  32'(act_rw), 32'(tbl[i].e_rw));
            chk($sformatf("vec%0d.writeReg", i),  32'(act_wr), 32'(tbl[i].e_wr));
            chk($sformatf("vec%0d.writeData", i), act_wd, tbl[i].e_wd);
            chk($sformatf("vec%0d.conflict", i),  32'(act_cnt), 32'(tbl[i].e_cnt));
        end

        // random traffic against the model, with a starvation watch
        alu_wait = 0; mem_wait = 0;
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 9) != 0);
            av = 1'($urandom_range(0, 1));
            mv = 1'($urandom_range(0, 1));
            step(en, av, 5'($urandom_range(0, 31)), $urandom, mv, 5'($urandom_range(0, 31)), $urandom);
            chk_model($sformatf("rnd%0d", i));
            alu_wait = (en && av && !act_ar) ? alu_wait + 1 : 0;
            mem_wait = (en && mv && !act_mr) ? mem_wait + 1 : 0;
            chk($sformatf("rnd%0d.alu_starve", i), 32'(alu_wait <= 1), 32'd1);
            chk($sformatf("rnd%0d.mem_starve", i), 32'(mem_wait <= 1), 32'd1);
        end

        // saturation: drive contention up to 0xFFFE, then three more cycles
        while (m_cnt < 65534) step(1'b1, 1'b1, 5'd0, 32'h0, 1'b1, 5'd0, 32'h0);
        chk("sat.preload", 32'(conflict_cnt), 32'h0000FFFE);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 5'd9, 32'hC0DE0000 + 32'(i), 1'b1, 5'd10, 32'hFEED0000 + 32'(i));
        chk("sat.final", 32'(act_cnt), 32'h0000FFFF);
        chk_model("sat");

        // reset pulsed between edges while a write is registered
        step(1'b1, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 32'h0);
        chk("mid.pre_regWrite", 32'(act_rw), 32'd1);
        wb_en = 1'b1; alu_valid = 1'b1; mem_valid = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("mid.alu_ready", 32'(alu_ready), 32'd0);
        chk("mid.mem_ready", 32'(mem_ready), 32'd0);
        chk("mid.regWrite",  32'(regWrite), 32'd0);
        chk("mid.writeReg",  32'(writeReg), 32'd0);
        chk("mid.writeData", writeData, 32'd0);
        chk("mid.conflict",  32'(conflict_cnt), 32'd0);
        wb_en = 1'b0;
        #1 reset_n = 1'b1;
        model_reset();
        @(negedge clk);
        step(1'b1, 1'b1, 5'd3, 32'h0BADF00D, 1'b1, 5'd4, 32'hCAFEF00D);
        chk("post.alu_first", 32'(act_ar), 32'd1);
        chk_model("post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, bad=%0d", bad);
        $fatal(1, "timeout");
    end

endmodule
